interrupt_ack_eoi_control: RTL

// - Counterpart of the in-service register: produces its latch_in_service, interrupt, end_of_interrupt
//   and priority_rotate inputs. Runs the 8086-mode two-pulse INTA acknowledge sequence and drives the vector byte.
// - Decodes OCW2 writes (EOI, specific EOI, rotate, set-priority) and performs auto-EOI.
// - Sits between bus/control logic (INTA, OCW2 strobe) and the ISR/priority-resolver datapath.

---
 rtl/pic8259_pkg.sv | 35 +++
 rtl/interrupt_ack_eoi_control_if.sv | 22 ++
 rtl/ocw2_eoi_decoder.sv | 45 ++++
 rtl/interrupt_ack_eoi_control.sv | 116 +++++++++++
 4 files changed

// File: rtl/pic8259_pkg.sv
// Shared types and helpers for the 8259-style interrupt controller datapath:
// OCW2 command codes, acknowledge FSM states and level/one-hot conversions.
package pic8259_pkg;

    // OCW2 {R,SL,EOI} command field
    typedef enum logic [2:0] {
        OCW2_AEOI_CLR   = 3'b000,
        OCW2_NS_EOI     = 3'b001,
        OCW2_NOP        = 3'b010,
        OCW2_SP_EOI     = 3'b011,
        OCW2_AEOI_SET   = 3'b100,
        OCW2_ROT_NS_EOI = 3'b101,
        OCW2_SET_PRIO   = 3'b110,
        OCW2_ROT_SP_EOI = 3'b111
    } ocw2_cmd_e;

    typedef enum logic [1:0] {
        ACK_IDLE,
        ACK_FIRST,
        ACK_WAIT2,
        ACK_SECOND
    } ack_state_e;

    function automatic logic [7:0] num2bit(input logic [2:0] num);
        num2bit = 8'h01 << num;
    endfunction

    // Lowest set bit wins; an all-zero input maps to 0.
    function automatic logic [2:0] bit2num(input logic [7:0] onehot);
        bit2num = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (onehot[i]) bit2num = 3'(i);
    endfunction

endpackage

// File: rtl/interrupt_ack_eoi_control_if.sv
// CPU-side bus view of the acknowledge/EOI block: INTA strobe, OCW2 write,
// ICW configuration and the vector byte driven back onto the data bus.
interface interrupt_ack_eoi_control_if;
    logic       inta_n;
    logic [4:0] icw2_vector_base;
    logic       auto_eoi_config;
    logic       ocw2_write;
    logic [7:0] ocw2_data;
    logic [7:0] vector_data;
    logic       vector_data_oe;
    logic       ack_in_progress;

    modport master (
        output inta_n, icw2_vector_base, auto_eoi_config, ocw2_write, ocw2_data,
        input  vector_data, vector_data_oe, ack_in_progress
    );

    modport slave (
        input  inta_n, icw2_vector_base, auto_eoi_config, ocw2_write, ocw2_data,
        output vector_data, vector_data_oe, ack_in_progress
    );
endinterface

// File: rtl/ocw2_eoi_decoder.sv
// Combinational OCW2 decode: EOI clear mask, priority rotate load and
// rotate-in-auto-EOI mode set/clear.
module ocw2_eoi_decoder
    import pic8259_pkg::*;
(
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    input  logic [7:0] highest_level_in_service,
    output logic [7:0] eoi_mask,
    output logic       rotate_load,
    output logic [2:0] rotate_value,
    output logic       aeoi_set,
    output logic       aeoi_clear
);
    ocw2_cmd_e cmd;
    assign cmd = ocw2_cmd_e'(ocw2_data[7:5]);

    always_comb begin
        eoi_mask     = 8'h00;
        rotate_load  = 1'b0;
        rotate_value = ocw2_data[2:0];
        aeoi_set     = 1'b0;
        aeoi_clear   = 1'b0;
        // bits 4:3 non-zero select ICW1/OCW3, not ours
        if (ocw2_write && ocw2_data[4:3] == 2'b00) begin
            case (cmd)
                OCW2_NS_EOI: eoi_mask = highest_level_in_service;
                OCW2_SP_EOI: eoi_mask = num2bit(ocw2_data[2:0]);
                OCW2_ROT_NS_EOI: begin
                    eoi_mask     = highest_level_in_service;
                    rotate_load  = |highest_level_in_service;
                    rotate_value = bit2num(highest_level_in_service);
                end
                OCW2_ROT_SP_EOI: begin
                    eoi_mask    = num2bit(ocw2_data[2:0]);
                    rotate_load = 1'b1;
                end
                OCW2_SET_PRIO: rotate_load = 1'b1;
                OCW2_AEOI_SET: aeoi_set    = 1'b1;
                OCW2_AEOI_CLR: aeoi_clear  = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/interrupt_ack_eoi_control.sv
// 8086-mode two-pulse INTA acknowledge sequencer with vector drive, OCW2 EOI /
// rotation handling and auto-EOI; feeds the in-service and priority blocks.
module interrupt_ack_eoi_control
    import pic8259_pkg::*;
#(
    parameter logic [2:0] ROTATE_RESET = 3'b111
) (
    input  logic                         clock,
    input  logic                         reset_n,
    interrupt_ack_eoi_control_if.slave   bus,
    input  logic [7:0]                   highest_level_request,
    input  logic [7:0]                   highest_level_in_service,
    output logic                         latch_in_service,
    output logic [7:0]                   interrupt,
    output logic [7:0]                   clear_interrupt_request,
    output logic [7:0]                   end_of_interrupt,
    output logic [2:0]                   priority_rotate
);
    ack_state_e state, state_nxt;
    logic       inta_prev, inta_fall, inta_rise;
    logic       capture, vec_load, ack_done, auto_eoi;
    logic [7:0] level;
    logic       spurious;
    logic       rotate_in_aeoi;

    logic [7:0] ocw_eoi;
    logic       ocw_rot_load, aeoi_set, aeoi_clear;
    logic [2:0] ocw_rot_value;

    ocw2_eoi_decoder u_ocw2 (
        .ocw2_write               (bus.ocw2_write),
        .ocw2_data                (bus.ocw2_data),
        .highest_level_in_service (highest_level_in_service),
        .eoi_mask                 (ocw_eoi),
        .rotate_load              (ocw_rot_load),
        .rotate_value             (ocw_rot_value),
        .aeoi_set                 (aeoi_set),
        .aeoi_clear               (aeoi_clear)
    );

    assign inta_fall = inta_prev & ~bus.inta_n;
    assign inta_rise = ~inta_prev & bus.inta_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ACK_IDLE;
        else          state <= state_nxt;
    end

    // Edges arriving in the wrong phase are dropped by simply not matching here.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        vec_load  = 1'b0;
        ack_done  = 1'b0;
        case (state)
            ACK_IDLE:   if (inta_fall) begin state_nxt = ACK_FIRST;  capture  = 1'b1; end
            ACK_FIRST:  if (inta_rise)       state_nxt = ACK_WAIT2;
            ACK_WAIT2:  if (inta_fall) begin state_nxt = ACK_SECOND; vec_load = 1'b1; end
            ACK_SECOND: if (inta_rise) begin state_nxt = ACK_IDLE;   ack_done = 1'b1; end
            default:                         state_nxt = ACK_IDLE;
        endcase
    end

    assign auto_eoi = ack_done & bus.auto_eoi_config & ~spurious;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inta_prev               <= 1'b1;
            latch_in_service        <= 1'b0;
            interrupt               <= 8'h00;
            clear_interrupt_request <= 8'h00;
            end_of_interrupt        <= 8'h00;
            priority_rotate         <= ROTATE_RESET;
            rotate_in_aeoi          <= 1'b0;
            level                   <= 8'h00;
            spurious                <= 1'b0;
            bus.vector_data         <= 8'h00;
            bus.vector_data_oe      <= 1'b0;
            bus.ack_in_progress     <= 1'b0;
        end else begin
            inta_prev               <= bus.inta_n;
            latch_in_service        <= 1'b0;
            interrupt               <= 8'h00;
            clear_interrupt_request <= 8'h00;
            if (capture) begin
                if (|highest_level_request) begin
                    level                   <= highest_level_request;
                    spurious                <= 1'b0;
                    latch_in_service        <= 1'b1;
                    interrupt               <= highest_level_request;
                    clear_interrupt_request <= highest_level_request;
                end else begin
                    // nothing pending: answer as IR7 without touching ISR/IRR
                    level    <= 8'h80;
                    spurious <= 1'b1;
                end
            end
            if (vec_load) begin
                bus.vector_data    <= {bus.icw2_vector_base, bit2num(level)};
                bus.vector_data_oe <= 1'b1;
            end
            if (ack_done) begin
                bus.vector_data    <= 8'h00;
                bus.vector_data_oe <= 1'b0;
            end
            bus.ack_in_progress <= (state_nxt != ACK_IDLE);
            end_of_interrupt    <= ocw_eoi | (auto_eoi ? level : 8'h00);
            if (ocw_rot_load)
                priority_rotate <= ocw_rot_value;
            else if (auto_eoi && rotate_in_aeoi)
                priority_rotate <= bit2num(level);
            if (aeoi_set)        rotate_in_aeoi <= 1'b1;
            else if (aeoi_clear) rotate_in_aeoi <= 1'b0;
        end
    end
endmodule
